// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// serdes_pkg : shared word width and transmit FSM encoding for the serdes pair
// Rev 1.0
// ============================================================================
package serdes_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } pts_state_t;

endpackage
`default_nettype wire

// File: rtl/pts_reg_if.sv
`default_nettype none
// ============================================================================
// pts_reg_if : word handshake and serial-side signals of the pts_reg block
// Rev 1.0
// ============================================================================
interface pts_reg_if
   import serdes_pkg::*;
#(
   parameter int WIDTH = WORD_W
) ();

   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;
   logic             start;
   logic             out;
   logic             busy;
   logic             done;

   modport master (
      output data, valid,
      input  ready, start, out, busy, done
   );

   modport slave (
      input  data, valid,
      output ready, start, out, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/pts_reg.sv
`default_nettype none
// ============================================================================
// pts_reg : parallel-to-serial stage, one-cycle start pulse then MSB-first bits
// Rev 1.0
// ============================================================================
module pts_reg
   import serdes_pkg::*;
#(
   parameter int WIDTH      = WORD_W,
   parameter int GAP_CYCLES = 1
) (
   input  wire logic clk,
   input  wire logic rst_n,
   pts_reg_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] C_LAST_GAP = GAP_W'(GAP_CYCLES - 1);

   if (WIDTH < 2) begin : g_bad_width
      $error("pts_reg: WIDTH must be at least 2");
   end
   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("pts_reg: GAP_CYCLES must be at least 1");
   end

   pts_state_t       r_state;
   pts_state_t       w_next;
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_valid;
   logic [WIDTH-1:0] r_shift;
   logic [CNT_W-1:0] r_cnt;
   logic [GAP_W-1:0] r_gap;
   logic             w_accept;
   logic             w_load;
   logic             w_start;
   logic             w_out;
   logic             w_busy;
   logic             w_done;

   // Accept and load are mutually exclusive: a full holding register blocks accept.
   assign w_accept = bus.valid && !r_hold_valid;
   assign w_load   = (r_state == IDLE) && r_hold_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_out   = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_hold_valid) begin
               w_next = START;
            end
         end
         START: begin
            w_start = 1'b1;
            w_busy  = 1'b1;
            w_next  = SHIFT;
         end
         SHIFT: begin
            w_out  = r_shift[WIDTH-1];
            w_busy = 1'b1;
            if (r_cnt == C_LAST_BIT) begin
               w_next = GAP;
            end
         end
         GAP: begin
            w_busy = 1'b1;
            w_done = (r_gap == '0);
            if (r_gap == C_LAST_GAP) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_shift      <= '0;
         r_cnt        <= '0;
         r_gap        <= '0;
      end else begin
         if (w_accept) begin
            r_hold       <= bus.data;
            r_hold_valid <= 1'b1;
         end else if (w_load) begin
            r_hold_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (r_hold_valid) begin
                  r_shift <= r_hold;
               end
            end
            START: begin
               r_cnt <= '0;
               r_gap <= '0;
            end
            SHIFT: begin
               r_shift <= {r_shift[WIDTH-2:0], 1'b0};
               r_cnt   <= r_cnt + 1'b1;
            end
            GAP: begin
               r_gap <= r_gap + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ready = !r_hold_valid;
   assign bus.start = w_start;
   assign bus.out   = w_out;
   assign bus.busy  = w_busy;
   assign bus.done  = w_done;

endmodule
`default_nettype wire

// File: tb/tb_pts_reg.sv
`default_nettype none
// ============================================================================
// tb_pts_reg : directed vector table plus sequences for pts_reg framing
// Rev 1.0
// ============================================================================
module tb_pts_reg;

   localparam int W      = 32;
   localparam int GAP    = 1;
   localparam int PERIOD = 1 + W + GAP + 1;

   typedef struct {
      logic [W-1:0] word;
      int           ones;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pts_reg_if #(.WIDTH(W)) bus ();

   pts_reg #(
      .WIDTH      (W),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int           n_pass = 0;
   int           n_total = 0;
   int           cyc = 0;
   logic [W-1:0] rx_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] tx_q[$];
   int           st_q[$];
   bit           acc_busy_q[$];
   int           nr_cycles = 0;
   logic [W-1:0] rx_sh = '0;
   int           rx_cnt = 0;
   bit           rx_active = 1'b0;
   int           bad_start_out = 0;
   vec_t         vecs[5];

   always @(posedge clk) cyc++;

   // Receiver model: a start pulse opens a frame, the next W cycles carry MSB first.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_active = 1'b0;
         rx_cnt    = 0;
      end else if (rx_active) begin
         rx_sh = {rx_sh[W-2:0], bus.out};
         rx_cnt++;
         if (rx_cnt == W) begin
            rx_q.push_back(rx_sh);
            rx_active = 1'b0;
         end
      end else if (bus.start) begin
         rx_active = 1'b1;
         rx_cnt    = 0;
         st_q.push_back(cyc);
         if (bus.out !== 1'b0) bad_start_out++;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", nm, act, req);
   endtask

   function automatic logic [4:0] outs();
      return {bus.ready, bus.start, bus.out, bus.busy, bus.done};
   endfunction

   task automatic run_frame(input logic [W-1:0] w, input int ones, input string nm);
      int           t_start = -1;
      int           t_done  = -1;
      int           n_busy  = 0;
      int           n_start = 0;
      int           n_ones  = 0;
      logic         rdy1    = 1'b1;
      logic [W-1:0] got     = '0;
      rx_q.delete();
      @(negedge clk);
      bus.valid = 1'b1;
      bus.data  = w;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bus.valid = 1'b0;
            bus.data  = ~w;
            rdy1      = bus.ready;
         end
         if (bus.start) begin
            n_start++;
            if (t_start < 0) t_start = c;
         end
         if (bus.busy) n_busy++;
         if (bus.done && t_done < 0) t_done = c;
         if (bus.out) n_ones++;
      end
      if (rx_q.size() > 0) got = rx_q.pop_front();
      chk({nm, "_ready_drop"}, rdy1, 0);
      chk({nm, "_start_lat"}, t_start, 2);
      chk({nm, "_starts"}, n_start, 1);
      chk({nm, "_done_lat"}, t_done, 35);
      chk({nm, "_busy_cycles"}, n_busy, 34);
      chk({nm, "_ones"}, n_ones, ones);
      chk({nm, "_word"}, got, w);
   endtask

   // Holds valid high across tx_q; data is scrambled whenever ready is low.
   task automatic stream(input int n, input string nm);
      int   i = 0;
      int   guard = 0;
      logic pend = 1'b0;
      logic pend_busy = 1'b0;
      acc_busy_q.delete();
      nr_cycles = 0;
      while (i < n && guard < n * 40 + 100) begin
         @(negedge clk);
         guard++;
         if (pend) begin
            exp_q.push_back(tx_q[i]);
            acc_busy_q.push_back(pend_busy);
            i++;
         end
         if (i < n) begin
            pend      = bus.ready;
            pend_busy = bus.busy;
            bus.valid = 1'b1;
            if (bus.ready) begin
               bus.data = tx_q[i];
            end else begin
               bus.data = $urandom;
               nr_cycles++;
            end
         end else begin
            bus.valid = 1'b0;
         end
      end
      bus.valid = 1'b0;
      chk({nm, "_accepted"}, i, n);
   endtask

   task automatic wait_rx(input int n, input string nm);
      int g = 0;
      while (rx_q.size() < n && g < n * PERIOD + 100) begin
         @(posedge clk);
         g++;
      end
      chk({nm, "_frames"}, rx_q.size(), n);
      for (int k = 0; k < n && k < rx_q.size() && k < exp_q.size(); k++)
         chk($sformatf("%s_word%0d", nm, k), rx_q[k], exp_q[k]);
   endtask

   initial begin
      int g;
      bus.valid = 1'b0;
      bus.data  = '0;

      #3 rst_n = 1'b0;
      #1 chk("async_reset_out", outs(), 5'b10000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("idle%0d", i), outs(), 5'b10000);
      end

      vecs[0] = '{word: 32'h8000_0001, ones: 2};
      vecs[1] = '{word: 32'h0000_0000, ones: 0};
      vecs[2] = '{word: 32'hFFFF_FFFF, ones: 32};
      vecs[3] = '{word: 32'hDEAD_BEEF, ones: 24};
      vecs[4] = '{word: 32'h0000_FFFF, ones: 16};
      for (int v = 0; v < 5; v++)
         run_frame(vecs[v].word, vecs[v].ones, $sformatf("vec%0d", v));

      rx_q.delete(); exp_q.delete(); st_q.delete();
      tx_q = '{32'hA5A5_A5A5, 32'h0F0F_F0F0, 32'hFFFF_FFFF};
      stream(3, "b2b");
      wait_rx(3, "b2b");
      repeat (5) @(negedge clk);
      chk("b2b_starts", st_q.size(), 3);
      if (st_q.size() == 3) begin
         chk("b2b_period1", st_q[1] - st_q[0], PERIOD);
         chk("b2b_period2", st_q[2] - st_q[1], PERIOD);
      end
      if (acc_busy_q.size() == 3) begin
         chk("b2b_acc2_in_frame", acc_busy_q[1], 1);
         chk("b2b_acc3_in_frame", acc_busy_q[2], 1);
      end
      chk("b2b_backpressure_seen", nr_cycles > 0, 1);

      rx_q.delete(); exp_q.delete(); st_q.delete();
      tx_q = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
      stream(2, "rst_pre");
      g = 0;
      while (!(rx_active && rx_cnt >= 11) && g < 100) begin
         @(posedge clk);
         g++;
      end
      chk("rst_reach_bit10", rx_cnt, 11);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_out", outs(), 5'b10000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rx_q.delete(); st_q.delete();
      repeat (60) @(negedge clk);
      chk("rst_pending_dropped", st_q.size(), 0);
      run_frame(32'h1234_5678, 13, "post_rst");

      rx_q.delete(); exp_q.delete(); st_q.delete(); tx_q.delete();
      for (int k = 0; k < 100; k++) tx_q.push_back($urandom);
      stream(100, "loop");
      wait_rx(100, "loop");

      chk("start_out_low", bad_start_out, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
